// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states,
// RV32I major opcodes, datapath mux/ALU selects and the control word.
package multicycle_pkg;

  localparam logic [3:0] S_IF      = 4'd0;
  localparam logic [3:0] S_ID      = 4'd1;
  localparam logic [3:0] S_EX      = 4'd2;
  localparam logic [3:0] S_MEM     = 4'd3;
  localparam logic [3:0] S_WB      = 4'd4;
  localparam logic [3:0] S_JALR_WB = 4'd5;
  localparam logic [3:0] S_PC_INC  = 4'd6;
  localparam logic [3:0] S_HALT    = 4'd7;

  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'd0,
    ALU_BRANCH = 2'd1,
    ALU_FUNCT  = 2'd2,
    ALU_RSVD   = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B    = 2'd0,
    SRCB_FOUR = 2'd1,
    SRCB_IMM  = 2'd2,
    SRCB_RSVD = 2'd3
  } alu_src_b_e;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_ALU    = 2'd2,
    WB_RSVD   = 2'd3
  } wb_sel_e;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       pc_source;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    wb_sel_e    wb_sel;
    logic       is_ecall;
    logic       illegal_inst;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = ctrl_t'(16'h0000);

  // Opcodes that take the EX path; everything else except SYSTEM is illegal.
  function automatic logic is_exec_op(input logic [6:0] op);
    case (op)
      OP_ARITH, OP_IMM, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR: is_exec_op = 1'b1;
      default:                    is_exec_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Shared instruction/data memory port handshake between the control unit
// (master) and the memory (slave).
interface multicycle_control_unit_if;
  logic mem_ready;
  logic mem_read;
  logic mem_write;
  logic i_or_d;

  modport master (input mem_ready, output mem_read, output mem_write, output i_or_d);
  modport slave  (output mem_ready, input mem_read, input mem_write, input i_or_d);
endinterface

// File: rtl/mc_ctrl_decode.sv
// Moore control-word decode: (state, opcode, mem_ready, bcond) -> strobes
// and mux selects for the multi-cycle datapath.
module mc_ctrl_decode
  import multicycle_pkg::*;
(
  input  logic [3:0] state,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       bcond,
  output ctrl_t      ctrl
);

  // Per-state control word; anything not set stays at its idle value.
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = mem_ready;
      end
      S_ID: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        if (opcode == OP_SYSTEM) begin
          ctrl.is_ecall = 1'b1;
        end else begin
          ctrl.illegal_inst = !is_exec_op(opcode);
        end
      end
      S_EX: begin
        case (opcode)
          OP_ARITH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALU_FUNCT;
          end
          OP_IMM: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_FUNCT;
          end
          OP_LOAD, OP_STORE, OP_JALR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
          end
          OP_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALU_BRANCH;
            ctrl.pc_write  = bcond;
            ctrl.pc_source = bcond;
          end
          OP_JAL: begin
            // Link value PC+4 comes straight off the ALU; target sits in ALUOut from ID.
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.wb_sel    = WB_ALU;
            ctrl.reg_write = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = 1'b1;
          end
          default: ctrl = CTRL_IDLE;
        endcase
      end
      S_MEM: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_read  = (opcode == OP_LOAD);
        ctrl.mem_write = (opcode == OP_STORE);
      end
      S_WB: begin
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.reg_write = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 1'b0;
        if (opcode == OP_LOAD) begin
          ctrl.wb_sel = WB_MDR;
        end else begin
          ctrl.wb_sel = WB_ALUOUT;
        end
      end
      S_JALR_WB: begin
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.wb_sel    = WB_ALU;
        ctrl.reg_write = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 1'b1;
      end
      S_PC_INC: begin
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 1'b0;
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: state register, next-state logic, memory
// wait timeout and cycle/retired-instruction counters around mc_ctrl_decode.
module multicycle_control_unit
  import multicycle_pkg::*;
#(
  parameter int unsigned CNT_W       = 32'd32,
  parameter int unsigned MEM_TIMEOUT = 32'd0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [6:0]                   opcode,
  input  logic                         alu_bcond,
  input  logic                         halt_req,
  multicycle_control_unit_if.master    mem,
  output logic                         pc_write,
  output logic                         ir_write,
  output logic                         reg_write,
  output logic                         pc_source,
  output logic                         alu_src_a,
  output logic [1:0]                   alu_src_b,
  output logic [1:0]                   alu_op,
  output logic [1:0]                   wb_sel,
  output logic                         is_ecall,
  output logic                         illegal_inst,
  output logic                         halted,
  output logic                         mem_fault,
  output logic [3:0]                   state,
  output logic [CNT_W-1:0]             cycle_count,
  output logic [CNT_W-1:0]             instret
);

  localparam logic [31:0]      TIMEOUT_LAST = MEM_TIMEOUT - 32'd1;
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       state_r;
  logic [3:0]       state_next_s;
  logic [31:0]      wait_cnt_r;
  logic             wait_expired_s;
  logic             fault_s;
  logic             retire_s;
  logic [CNT_W-1:0] cycle_count_r;
  logic [CNT_W-1:0] instret_r;
  logic             halted_r;
  logic             mem_fault_r;
  ctrl_t            ctrl_s;
  ctrl_t            ctrl_out_s;

  mc_ctrl_decode u_decode (
    .state     (state_r),
    .opcode    (opcode),
    .mem_ready (mem.mem_ready),
    .bcond     (alu_bcond),
    .ctrl      (ctrl_s)
  );

  // Next-state selection, timeout detection and retirement qualification.
  always_comb begin
    state_next_s   = state_r;
    fault_s        = 1'b0;
    wait_expired_s = (MEM_TIMEOUT != 32'd0) && (wait_cnt_r == TIMEOUT_LAST) && !mem.mem_ready;
    case (state_r)
      S_IF: begin
        if (mem.mem_ready) begin
          state_next_s = S_ID;
        end else if (wait_expired_s) begin
          state_next_s = S_HALT;
          fault_s      = 1'b1;
        end else begin
          state_next_s = S_IF;
        end
      end
      S_ID: begin
        if (opcode == OP_SYSTEM) begin
          state_next_s = halt_req ? S_HALT : S_PC_INC;
        end else if (is_exec_op(opcode)) begin
          state_next_s = S_EX;
        end else begin
          state_next_s = S_PC_INC;
        end
      end
      S_EX: begin
        case (opcode)
          OP_ARITH, OP_IMM:  state_next_s = S_WB;
          OP_LOAD, OP_STORE: state_next_s = S_MEM;
          OP_BRANCH:         state_next_s = alu_bcond ? S_IF : S_PC_INC;
          OP_JAL:            state_next_s = S_IF;
          OP_JALR:           state_next_s = S_JALR_WB;
          default:           state_next_s = S_PC_INC;
        endcase
      end
      S_MEM: begin
        if (mem.mem_ready) begin
          state_next_s = (opcode == OP_LOAD) ? S_WB : S_PC_INC;
        end else if (wait_expired_s) begin
          state_next_s = S_HALT;
          fault_s      = 1'b1;
        end else begin
          state_next_s = S_MEM;
        end
      end
      S_WB, S_JALR_WB, S_PC_INC: state_next_s = S_IF;
      S_HALT:                    state_next_s = S_HALT;
      default:                   state_next_s = S_IF;
    endcase
    retire_s = (state_next_s == S_IF) &&
               (state_r inside {S_ID, S_EX, S_WB, S_JALR_WB, S_PC_INC});
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IF;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Consecutive not-ready cycles in the current IF/MEM visit; any state change restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_r <= 32'd0;
    end else if (state_next_s != state_r) begin
      wait_cnt_r <= 32'd0;
    end else if (!mem.mem_ready && (state_r == S_IF || state_r == S_MEM)) begin
      wait_cnt_r <= wait_cnt_r + 32'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Performance counters; both freeze once halted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count_r <= {CNT_W{1'b0}};
      instret_r     <= {CNT_W{1'b0}};
    end else begin
      cycle_count_r <= (state_r != S_HALT) ? cycle_count_r + CNT_ONE : cycle_count_r;
      instret_r     <= retire_s ? instret_r + CNT_ONE : instret_r;
    end
  end

  // Sticky halt and memory-fault flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted_r    <= 1'b0;
      mem_fault_r <= 1'b0;
    end else begin
      halted_r    <= halted_r | (state_next_s == S_HALT);
      mem_fault_r <= mem_fault_r | fault_s;
    end
  end

  // Reset gates the strobes combinationally so an in-flight access aborts at once.
  assign ctrl_out_s = reset ? ctrl_s : CTRL_IDLE;

  assign mem.mem_read  = ctrl_out_s.mem_read;
  assign mem.mem_write = ctrl_out_s.mem_write;
  assign mem.i_or_d    = ctrl_out_s.i_or_d;
  assign pc_write      = ctrl_out_s.pc_write;
  assign ir_write      = ctrl_out_s.ir_write;
  assign reg_write     = ctrl_out_s.reg_write;
  assign pc_source     = ctrl_out_s.pc_source;
  assign alu_src_a     = ctrl_out_s.alu_src_a;
  assign alu_src_b     = ctrl_out_s.alu_src_b;
  assign alu_op        = ctrl_out_s.alu_op;
  assign wb_sel        = ctrl_out_s.wb_sel;
  assign is_ecall      = ctrl_out_s.is_ecall;
  assign illegal_inst  = ctrl_out_s.illegal_inst;
  assign halted        = halted_r;
  assign mem_fault     = mem_fault_r;
  assign state         = state_r;
  assign cycle_count   = cycle_count_r;
  assign instret       = instret_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed scoreboard bench for multicycle_control_unit (MEM_TIMEOUT = 4).
module tb_multicycle_control_unit;
  import multicycle_pkg::*;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        alu_bcond;
  logic        halt_req;
  logic        pc_write, ir_write, reg_write, pc_source, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, wb_sel;
  logic        is_ecall, illegal_inst, halted, mem_fault;
  logic [3:0]  state;
  logic [31:0] cycle_count, instret;

  multicycle_control_unit_if mif ();

  multicycle_control_unit #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .alu_bcond    (alu_bcond),
    .halt_req     (halt_req),
    .mem          (mif),
    .pc_write     (pc_write),
    .ir_write     (ir_write),
    .reg_write    (reg_write),
    .pc_source    (pc_source),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .wb_sel       (wb_sel),
    .is_ecall     (is_ecall),
    .illegal_inst (illegal_inst),
    .halted       (halted),
    .mem_fault    (mem_fault),
    .state        (state),
    .cycle_count  (cycle_count),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word: {halted, mem_fault, pc_write, ir_write, reg_write, mem_read, mem_write,
  //                 i_or_d, pc_source, alu_src_a, alu_src_b, alu_op, wb_sel, is_ecall, illegal_inst}
  localparam logic [17:0] C_ZERO    = 18'd0;
  localparam logic [17:0] C_IF_RDY  = {2'b00, 8'b0101_0000, 2'd1, 2'd0, 2'd0, 2'b00};
  localparam logic [17:0] C_IF_WAIT = {2'b00, 8'b0001_0000, 2'd1, 2'd0, 2'd0, 2'b00};
  localparam logic [17:0] C_ID      = {2'b00, 8'b0000_0000, 2'd2, 2'd0, 2'd0, 2'b00};
  localparam logic [17:0] C_ID_EC   = {2'b00, 8'b0000_0000, 2'd2, 2'd0, 2'd0, 2'b10};
  localparam logic [17:0] C_ID_ILL  = {2'b00, 8'b0000_0000, 2'd2, 2'd0, 2'd0, 2'b01};
  localparam logic [17:0] C_EX_R    = {2'b00, 8'b0000_0001, 2'd0, 2'd2, 2'd0, 2'b00};
  localparam logic [17:0] C_EX_I    = {2'b00, 8'b0000_0001, 2'd2, 2'd2, 2'd0, 2'b00};
  localparam logic [17:0] C_EX_LS   = {2'b00, 8'b0000_0001, 2'd2, 2'd0, 2'd0, 2'b00};
  localparam logic [17:0] C_EX_BT   = {2'b00, 8'b1000_0011, 2'd0, 2'd1, 2'd0, 2'b00};
  localparam logic [17:0] C_EX_BN   = {2'b00, 8'b0000_0001, 2'd0, 2'd1, 2'd0, 2'b00};
  localparam logic [17:0] C_EX_JAL  = {2'b00, 8'b1010_0010, 2'd1, 2'd0, 2'd2, 2'b00};
  localparam logic [17:0] C_EX_JALR = {2'b00, 8'b0000_0001, 2'd2, 2'd0, 2'd0, 2'b00};
  localparam logic [17:0] C_MEM_LD  = {2'b00, 8'b0001_0100, 2'd0, 2'd0, 2'd0, 2'b00};
  localparam logic [17:0] C_MEM_ST  = {2'b00, 8'b0000_1100, 2'd0, 2'd0, 2'd0, 2'b00};
  localparam logic [17:0] C_WB_R    = {2'b00, 8'b1010_0000, 2'd1, 2'd0, 2'd0, 2'b00};
  localparam logic [17:0] C_WB_LD   = {2'b00, 8'b1010_0000, 2'd1, 2'd0, 2'd1, 2'b00};
  localparam logic [17:0] C_JALR_WB = {2'b00, 8'b1010_0010, 2'd1, 2'd0, 2'd2, 2'b00};
  localparam logic [17:0] C_PC_INC  = {2'b00, 8'b1000_0000, 2'd1, 2'd0, 2'd0, 2'b00};
  localparam logic [17:0] C_HALT    = {2'b10, 8'b0000_0000, 2'd0, 2'd0, 2'd0, 2'b00};
  localparam logic [17:0] C_HALT_F  = {2'b11, 8'b0000_0000, 2'd0, 2'd0, 2'd0, 2'b00};

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [17:0] cw;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [17:0] obs_cw();
    return {halted, mem_fault, pc_write, ir_write, reg_write, mif.mem_read, mif.mem_write,
            mif.i_or_d, pc_source, alu_src_a, alu_src_b, alu_op, wb_sel, is_ecall, illegal_inst};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".state"}, {28'd0, state}, {28'd0, e.st});
      chk({e.tag, ".ctrl"}, {14'd0, obs_cw()}, {14'd0, e.cw});
    end
  endtask

  task automatic expect_now(input string tag, input logic [3:0] est, input logic [17:0] ecw);
    exp_t e;
    e.tag = tag;
    e.st  = est;
    e.cw  = ecw;
    sb.push_back(e);
    #1;
    pop_check();
  endtask

  // One clock cycle: drive inputs, check the Moore outputs, advance to the next negedge.
  task automatic cyc(input string tag, input logic [6:0] op, input logic rdy, input logic bc,
                     input logic hr, input logic [3:0] est, input logic [17:0] ecw);
    opcode        = op;
    mif.mem_ready = rdy;
    alu_bcond     = bc;
    halt_req      = hr;
    expect_now(tag, est, ecw);
    @(negedge clk);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b0;
    expect_now(tag, S_IF, C_ZERO);
    chk({tag, ".cycle"}, cycle_count, 32'd0);
    chk({tag, ".instret"}, instret, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset         = 1'b0;
    opcode        = OP_ARITH;
    mif.mem_ready = 1'b1;
    alu_bcond     = 1'b0;
    halt_req      = 1'b0;
    repeat (2) @(negedge clk);
    apply_reset("por");

    cyc("r_if", OP_ARITH, 1'b1, 1'b0, 1'b0, S_IF, C_IF_RDY);
    cyc("r_id", OP_ARITH, 1'b1, 1'b0, 1'b0, S_ID, C_ID);
    cyc("r_ex", OP_ARITH, 1'b1, 1'b0, 1'b0, S_EX, C_EX_R);
    cyc("r_wb", OP_ARITH, 1'b1, 1'b0, 1'b0, S_WB, C_WB_R);
    chk("r_cycle", cycle_count, 32'd4);
    chk("r_instret", instret, 32'd1);

    cyc("ld_if", OP_LOAD, 1'b1, 1'b0, 1'b0, S_IF, C_IF_RDY);
    cyc("ld_id", OP_LOAD, 1'b1, 1'b0, 1'b0, S_ID, C_ID);
    cyc("ld_ex", OP_LOAD, 1'b1, 1'b0, 1'b0, S_EX, C_EX_LS);
    for (int i = 0; i < 3; i++) cyc("ld_mem_wait", OP_LOAD, 1'b0, 1'b0, 1'b0, S_MEM, C_MEM_LD);
    cyc("ld_mem_rdy", OP_LOAD, 1'b1, 1'b0, 1'b0, S_MEM, C_MEM_LD);
    cyc("ld_wb", OP_LOAD, 1'b1, 1'b0, 1'b0, S_WB, C_WB_LD);
    chk("ld_cycle", cycle_count, 32'd12);
    chk("ld_instret", instret, 32'd2);

    cyc("bt_if", OP_BRANCH, 1'b1, 1'b1, 1'b0, S_IF, C_IF_RDY);
    cyc("bt_id", OP_BRANCH, 1'b1, 1'b1, 1'b0, S_ID, C_ID);
    cyc("bt_ex", OP_BRANCH, 1'b1, 1'b1, 1'b0, S_EX, C_EX_BT);
    chk("bt_cycle", cycle_count, 32'd15);
    chk("bt_instret", instret, 32'd3);

    cyc("bn_if", OP_BRANCH, 1'b1, 1'b0, 1'b0, S_IF, C_IF_RDY);
    cyc("bn_id", OP_BRANCH, 1'b1, 1'b0, 1'b0, S_ID, C_ID);
    cyc("bn_ex", OP_BRANCH, 1'b1, 1'b0, 1'b0, S_EX, C_EX_BN);
    cyc("bn_pcinc", OP_BRANCH, 1'b1, 1'b0, 1'b0, S_PC_INC, C_PC_INC);
    chk("bn_cycle", cycle_count, 32'd19);
    chk("bn_instret", instret, 32'd4);

    cyc("ec_if", OP_SYSTEM, 1'b1, 1'b0, 1'b0, S_IF, C_IF_RDY);
    cyc("ec_id", OP_SYSTEM, 1'b1, 1'b0, 1'b0, S_ID, C_ID_EC);
    cyc("ec_pcinc", OP_SYSTEM, 1'b1, 1'b0, 1'b0, S_PC_INC, C_PC_INC);
    chk("ec_instret", instret, 32'd5);

    cyc("jal_if", OP_JAL, 1'b1, 1'b0, 1'b0, S_IF, C_IF_RDY);
    cyc("jal_id", OP_JAL, 1'b1, 1'b0, 1'b0, S_ID, C_ID);
    cyc("jal_ex", OP_JAL, 1'b1, 1'b0, 1'b0, S_EX, C_EX_JAL);
    chk("jal_instret", instret, 32'd6);

    cyc("jalr_if", OP_JALR, 1'b1, 1'b0, 1'b0, S_IF, C_IF_RDY);
    cyc("jalr_id", OP_JALR, 1'b1, 1'b0, 1'b0, S_ID, C_ID);
    cyc("jalr_ex", OP_JALR, 1'b1, 1'b0, 1'b0, S_EX, C_EX_JALR);
    cyc("jalr_wb", OP_JALR, 1'b1, 1'b0, 1'b0, S_JALR_WB, C_JALR_WB);
    chk("jalr_cycle", cycle_count, 32'd29);

    cyc("imm_if", OP_IMM, 1'b1, 1'b0, 1'b0, S_IF, C_IF_RDY);
    cyc("imm_id", OP_IMM, 1'b1, 1'b0, 1'b0, S_ID, C_ID);
    cyc("imm_ex", OP_IMM, 1'b1, 1'b0, 1'b0, S_EX, C_EX_I);
    cyc("imm_wb", OP_IMM, 1'b1, 1'b0, 1'b0, S_WB, C_WB_R);

    cyc("st_if", OP_STORE, 1'b1, 1'b0, 1'b0, S_IF, C_IF_RDY);
    cyc("st_id", OP_STORE, 1'b1, 1'b0, 1'b0, S_ID, C_ID);
    cyc("st_ex", OP_STORE, 1'b1, 1'b0, 1'b0, S_EX, C_EX_LS);
    cyc("st_mem", OP_STORE, 1'b1, 1'b0, 1'b0, S_MEM, C_MEM_ST);
    cyc("st_pcinc", OP_STORE, 1'b1, 1'b0, 1'b0, S_PC_INC, C_PC_INC);
    chk("st_cycle", cycle_count, 32'd38);
    chk("st_instret", instret, 32'd9);

    cyc("ill_if", 7'b1111111, 1'b1, 1'b0, 1'b0, S_IF, C_IF_RDY);
    cyc("ill_id", 7'b1111111, 1'b1, 1'b0, 1'b0, S_ID, C_ID_ILL);
    cyc("ill_pcinc", 7'b1111111, 1'b1, 1'b0, 1'b0, S_PC_INC, C_PC_INC);
    chk("ill_instret", instret, 32'd10);

    cyc("eh_if", OP_SYSTEM, 1'b1, 1'b0, 1'b1, S_IF, C_IF_RDY);
    cyc("eh_id", OP_SYSTEM, 1'b1, 1'b0, 1'b1, S_ID, C_ID_EC);
    for (int i = 0; i < 10; i++) cyc("eh_halt", OP_ARITH, 1'b1, 1'b0, 1'b0, S_HALT, C_HALT);
    chk("eh_cycle_frozen", cycle_count, 32'd43);
    chk("eh_instret", instret, 32'd10);

    mif.mem_ready = 1'b0;
    apply_reset("rst_to");
    for (int i = 0; i < 4; i++) cyc("to_if_wait", OP_ARITH, 1'b0, 1'b0, 1'b0, S_IF, C_IF_WAIT);
    cyc("to_halt", OP_ARITH, 1'b0, 1'b0, 1'b0, S_HALT, C_HALT_F);
    chk("to_cycle", cycle_count, 32'd5 - 32'd1);
    chk("to_instret", instret, 32'd0);

    mif.mem_ready = 1'b1;
    apply_reset("rst_ab");
    cyc("ab_if", OP_STORE, 1'b1, 1'b0, 1'b0, S_IF, C_IF_RDY);
    cyc("ab_id", OP_STORE, 1'b1, 1'b0, 1'b0, S_ID, C_ID);
    cyc("ab_ex", OP_STORE, 1'b1, 1'b0, 1'b0, S_EX, C_EX_LS);
    cyc("ab_mem", OP_STORE, 1'b0, 1'b0, 1'b0, S_MEM, C_MEM_ST);
    #2;
    chk("ab_mem_write_pre", {31'd0, mif.mem_write}, 32'd1);
    reset = 1'b0;
    expect_now("ab_abort", S_IF, C_ZERO);
    @(negedge clk);
    reset = 1'b1;
    chk("ab_cycle", cycle_count, 32'd0);
    chk("ab_instret", instret, 32'd0);
    cyc("ab_if2", OP_ARITH, 1'b1, 1'b0, 1'b0, S_IF, C_IF_RDY);
    chk("ab_cycle_run", cycle_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
